z80_regfile: RTL and testbench

//  Z80 general register file: main and alternate sets of A,F,B,C,D,E,H,L plus SP.

---
 rtl/z80_regfile_if.sv | 35 +++
 rtl/z80_regfile.sv | 120 ++++++++++++
 tb/tb_z80_regfile.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/z80_regfile_if.sv
// Z80 register file access bus: write-back, inc/dec, exchange and read ports.
// Master drives controls and selects; slave returns combinational read data.
interface z80_regfile_if;
  logic        Wr_Byte;
  logic [2:0]  Wr_Byte_Sel;
  logic        Wr_Pair;
  logic [1:0]  Wr_Pair_Sel;
  logic [15:0] Wr_Data;
  logic        F_Wr;
  logic [7:0]  F_In;
  logic        Inc;
  logic        Dec;
  logic [1:0]  Id_Sel;
  logic        Exx;
  logic        Ex_Af;
  logic        Ex_De_Hl;
  logic [2:0]  Rd_Byte_Sel;
  logic [7:0]  Rd_Byte;
  logic [1:0]  Rd_Pair_Sel;
  logic [15:0] Rd_Pair;
  logic [7:0]  A_out;
  logic [7:0]  F_out;

  modport master (
    output Wr_Byte, Wr_Byte_Sel, Wr_Pair, Wr_Pair_Sel, Wr_Data, F_Wr, F_In,
           Inc, Dec, Id_Sel, Exx, Ex_Af, Ex_De_Hl, Rd_Byte_Sel, Rd_Pair_Sel,
    input  Rd_Byte, Rd_Pair, A_out, F_out
  );

  modport slave (
    input  Wr_Byte, Wr_Byte_Sel, Wr_Pair, Wr_Pair_Sel, Wr_Data, F_Wr, F_In,
           Inc, Dec, Id_Sel, Exx, Ex_Af, Ex_De_Hl, Rd_Byte_Sel, Rd_Pair_Sel,
    output Rd_Byte, Rd_Pair, A_out, F_out
  );
endinterface

// File: rtl/z80_regfile.sv
// Z80 main/alternate register file with SP; writes land 1 clk after the edge, reads combinational.
// No backpressure: every control is accepted each cycle; exchanges are bank/swap bit flips.
module z80_regfile (
  input  logic         Clk,
  input  logic         Reset_n,
  z80_regfile_if.slave rf
);
  // gp storage: index = bank*6 + {B,C,D,E,H,L}
  logic [7:0]  gp_q [12];
  logic [7:0]  gp_d [12];
  logic [7:0]  a_q  [2];
  logic [7:0]  a_d  [2];
  logic [7:0]  f_q  [2];
  logic [7:0]  f_d  [2];
  logic [15:0] sp_q, sp_d;
  logic        af_bank_q, af_bank_d;
  logic        exx_bank_q, exx_bank_d;
  logic [1:0]  swap_q, swap_d;
  logic        act_swap;
  logic [7:0]  rd_byte;
  logic [15:0] rd_pair;
  logic [15:0] id_pair;
  logic [15:0] id_new;

  // Logical byte select to physical slot; the DE/HL swap bit exchanges D<->H, E<->L.
  function automatic logic [3:0] gp_idx(input logic bank, input logic swap,
                                        input logic [2:0] sel);
    logic [2:0] s;
    s = sel;
    if (swap && (sel == 3'd2 || sel == 3'd3))
      s = sel + 3'd2;
    else if (swap && (sel == 3'd4 || sel == 3'd5))
      s = sel - 3'd2;
    return bank ? (4'd6 + {1'b0, s}) : {1'b0, s};
  endfunction

  assign act_swap = swap_q[exx_bank_q];

  always_comb begin
    rd_byte = 8'h00;
    rd_pair = sp_q;
    id_pair = sp_q;
    if (rf.Rd_Byte_Sel == 3'b111)
      rd_byte = a_q[af_bank_q];
    else if (rf.Rd_Byte_Sel != 3'b110)
      rd_byte = gp_q[gp_idx(exx_bank_q, act_swap, rf.Rd_Byte_Sel)];
    if (rf.Rd_Pair_Sel != 2'b11)
      rd_pair = {gp_q[gp_idx(exx_bank_q, act_swap, {rf.Rd_Pair_Sel, 1'b0})],
                 gp_q[gp_idx(exx_bank_q, act_swap, {rf.Rd_Pair_Sel, 1'b1})]};
    if (rf.Id_Sel != 2'b11)
      id_pair = {gp_q[gp_idx(exx_bank_q, act_swap, {rf.Id_Sel, 1'b0})],
                 gp_q[gp_idx(exx_bank_q, act_swap, {rf.Id_Sel, 1'b1})]};
  end

  assign rf.Rd_Byte = rd_byte;
  assign rf.Rd_Pair = rd_pair;
  assign rf.A_out   = a_q[af_bank_q];
  assign rf.F_out   = f_q[af_bank_q];

  always_comb begin
    gp_d       = gp_q;
    a_d        = a_q;
    f_d        = f_q;
    sp_d       = sp_q;
    id_new     = rf.Inc ? (id_pair + 16'd1) : (id_pair - 16'd1);
    af_bank_d  = af_bank_q ^ rf.Ex_Af;
    exx_bank_d = exx_bank_q ^ rf.Exx;
    swap_d     = swap_q;
    // DE/HL swap belongs to the bank active before any same-cycle EXX.
    swap_d[exx_bank_q] = swap_q[exx_bank_q] ^ rf.Ex_De_Hl;

    if (rf.Wr_Byte) begin
      if (rf.Wr_Byte_Sel == 3'b111)
        a_d[af_bank_q] = rf.Wr_Data[7:0];
      else if (rf.Wr_Byte_Sel != 3'b110)
        gp_d[gp_idx(exx_bank_q, act_swap, rf.Wr_Byte_Sel)] = rf.Wr_Data[7:0];
    end
    if (rf.F_Wr)
      f_d[af_bank_q] = rf.F_In;
    // Pair write follows the byte write so it wins on an overlapping byte.
    if (rf.Wr_Pair) begin
      if (rf.Wr_Pair_Sel == 2'b11) begin
        sp_d = rf.Wr_Data;
      end else begin
        gp_d[gp_idx(exx_bank_q, act_swap, {rf.Wr_Pair_Sel, 1'b0})] = rf.Wr_Data[15:8];
        gp_d[gp_idx(exx_bank_q, act_swap, {rf.Wr_Pair_Sel, 1'b1})] = rf.Wr_Data[7:0];
      end
    end
    if (!rf.Wr_Pair && !rf.Wr_Byte && (rf.Inc ^ rf.Dec)) begin
      if (rf.Id_Sel == 2'b11) begin
        sp_d = id_new;
      end else begin
        gp_d[gp_idx(exx_bank_q, act_swap, {rf.Id_Sel, 1'b0})] = id_new[15:8];
        gp_d[gp_idx(exx_bank_q, act_swap, {rf.Id_Sel, 1'b1})] = id_new[7:0];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 12; i++) gp_q[i] <= 8'hFF;
      for (int i = 0; i < 2; i++) begin
        a_q[i] <= 8'hFF;
        f_q[i] <= 8'hFF;
      end
      sp_q       <= 16'hFFFF;
      af_bank_q  <= 1'b0;
      exx_bank_q <= 1'b0;
      swap_q     <= 2'b00;
    end else begin
      gp_q       <= gp_d;
      a_q        <= a_d;
      f_q        <= f_d;
      sp_q       <= sp_d;
      af_bank_q  <= af_bank_d;
      exx_bank_q <= exx_bank_d;
      swap_q     <= swap_d;
    end
  end
endmodule

// File: tb/tb_z80_regfile.sv
// Directed bench for z80_regfile: hand-computed expectations checked with immediate assertions.
module tb_z80_regfile;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  z80_regfile_if rf();

  z80_regfile dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .rf      (rf)
  );

  always #5 Clk = ~Clk;

  task automatic idle();
    rf.Wr_Byte = 1'b0; rf.Wr_Byte_Sel = 3'b000;
    rf.Wr_Pair = 1'b0; rf.Wr_Pair_Sel = 2'b00; rf.Wr_Data = 16'h0000;
    rf.F_Wr = 1'b0; rf.F_In = 8'h00;
    rf.Inc = 1'b0; rf.Dec = 1'b0; rf.Id_Sel = 2'b00;
    rf.Exx = 1'b0; rf.Ex_Af = 1'b0; rf.Ex_De_Hl = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    idle();
  endtask

  task automatic wpair(input logic [1:0] sel, input logic [15:0] d);
    rf.Wr_Pair = 1'b1; rf.Wr_Pair_Sel = sel; rf.Wr_Data = d;
    tick();
  endtask

  task automatic chk_pair(input string tag, input logic [1:0] sel, input logic [15:0] exp);
    rf.Rd_Pair_Sel = sel;
    #1;
    n_tests++;
    assert (rf.Rd_Pair === exp) else begin
      n_fail++;
      $error("FAIL %s: Rd_Pair got %h expected %h", tag, rf.Rd_Pair, exp);
    end
  endtask

  task automatic chk_byte(input string tag, input logic [2:0] sel, input logic [7:0] exp);
    rf.Rd_Byte_Sel = sel;
    #1;
    n_tests++;
    assert (rf.Rd_Byte === exp) else begin
      n_fail++;
      $error("FAIL %s: Rd_Byte got %h expected %h", tag, rf.Rd_Byte, exp);
    end
  endtask

  task automatic chk_af(input string tag, input logic [7:0] a, input logic [7:0] f);
    #1;
    n_tests++;
    assert (rf.A_out === a && rf.F_out === f) else begin
      n_fail++;
      $error("FAIL %s: A/F got %h/%h expected %h/%h", tag, rf.A_out, rf.F_out, a, f);
    end
  endtask

  localparam logic [1:0] BC = 2'd0, DE = 2'd1, HL = 2'd2, SP = 2'd3;

  initial begin
    idle();
    rf.Rd_Byte_Sel = 3'b000;
    rf.Rd_Pair_Sel = 2'b00;
    #12;
    chk_pair("rst_in_bc", BC, 16'hFFFF);
    @(posedge Clk); #1;
    Reset_n = 1'b1;

    // 1: reset state
    chk_pair("rst_bc", BC, 16'hFFFF);
    chk_pair("rst_de", DE, 16'hFFFF);
    chk_pair("rst_hl", HL, 16'hFFFF);
    chk_pair("rst_sp", SP, 16'hFFFF);
    chk_af("rst_af", 8'hFF, 8'hFF);
    chk_byte("rst_none", 3'b110, 8'h00);

    // 2: pair then byte write, and no write-through before the edge
    wpair(BC, 16'h1234);
    chk_pair("bc_1234", BC, 16'h1234);
    rf.Wr_Byte = 1'b1; rf.Wr_Byte_Sel = 3'b001; rf.Wr_Data = 16'h00AB;
    chk_pair("no_bypass", BC, 16'h1234);
    tick();
    chk_pair("bc_12ab", BC, 16'h12AB);
    chk_byte("b_12", 3'b000, 8'h12);
    chk_byte("c_ab", 3'b001, 8'hAB);

    // 3: EX DE,HL twice
    wpair(DE, 16'h1111);
    wpair(HL, 16'h2222);
    rf.Ex_De_Hl = 1'b1; tick();
    chk_pair("exdh_de", DE, 16'h2222);
    chk_pair("exdh_hl", HL, 16'h1111);
    chk_byte("exdh_d", 3'b010, 8'h22);
    rf.Ex_De_Hl = 1'b1; tick();
    chk_pair("exdh2_de", DE, 16'h1111);
    chk_pair("exdh2_hl", HL, 16'h2222);

    // 4: EXX banks
    wpair(HL, 16'hAAAA);
    rf.Exx = 1'b1; tick();
    chk_pair("alt_hl_rst", HL, 16'hFFFF);
    wpair(HL, 16'h5555);
    rf.Exx = 1'b1; tick();
    chk_pair("main_hl", HL, 16'hAAAA);
    chk_pair("main_bc", BC, 16'h12AB);
    rf.Exx = 1'b1; tick();
    chk_pair("alt_hl", HL, 16'h5555);
    rf.Exx = 1'b1; tick();

    // 5: EXX + EX DE,HL same cycle swaps the pre-EXX bank
    wpair(HL, 16'h1111);
    wpair(DE, 16'h2222);
    rf.Exx = 1'b1; rf.Ex_De_Hl = 1'b1; tick();
    chk_pair("x5_alt_hl", HL, 16'h5555);
    chk_pair("x5_alt_de", DE, 16'hFFFF);
    rf.Exx = 1'b1; tick();
    chk_pair("x5_hl", HL, 16'h2222);
    chk_pair("x5_de", DE, 16'h1111);
    rf.Wr_Byte = 1'b1; rf.Wr_Byte_Sel = 3'b100; rf.Wr_Data = 16'h0077; tick();
    chk_pair("swp_h_wr", HL, 16'h7722);
    chk_pair("swp_de_kept", DE, 16'h1111);
    rf.Ex_De_Hl = 1'b1; tick();
    chk_pair("unswp_hl", HL, 16'h1111);
    chk_pair("unswp_de", DE, 16'h7722);

    // 6: SP inc/dec wrap and suppression
    rf.Inc = 1'b1; rf.Id_Sel = SP; tick();
    chk_pair("sp_inc_wrap", SP, 16'h0000);
    rf.Dec = 1'b1; rf.Id_Sel = SP; tick();
    chk_pair("sp_dec_wrap", SP, 16'hFFFF);
    rf.Inc = 1'b1; rf.Id_Sel = SP;
    rf.Wr_Pair = 1'b1; rf.Wr_Pair_Sel = SP; rf.Wr_Data = 16'h0100; tick();
    chk_pair("sp_wr_wins", SP, 16'h0100);
    rf.Dec = 1'b1; rf.Id_Sel = BC; rf.Wr_Byte = 1'b1; rf.Wr_Byte_Sel = 3'b110; tick();
    chk_pair("dec_suppr", BC, 16'h12AB);
    rf.Inc = 1'b1; rf.Dec = 1'b1; rf.Id_Sel = BC; tick();
    chk_pair("incdec_nop", BC, 16'h12AB);
    rf.Dec = 1'b1; rf.Id_Sel = BC; tick();
    chk_pair("bc_dec", BC, 16'h12AA);

    // Accumulator/flags and EX AF,AF'
    rf.Wr_Byte = 1'b1; rf.Wr_Byte_Sel = 3'b111; rf.Wr_Data = 16'h005A;
    rf.F_Wr = 1'b1; rf.F_In = 8'hC3; tick();
    chk_af("af_wr", 8'h5A, 8'hC3);
    chk_byte("rd_a", 3'b111, 8'h5A);
    rf.Ex_Af = 1'b1; tick();
    chk_af("af_alt", 8'hFF, 8'hFF);
    rf.Wr_Byte = 1'b1; rf.Wr_Byte_Sel = 3'b111; rf.Wr_Data = 16'h0011; tick();
    rf.Ex_Af = 1'b1; rf.Exx = 1'b1; tick();
    chk_af("af_exx_both", 8'h5A, 8'hC3);
    chk_pair("exx_with_af", HL, 16'h5555);
    chk_pair("sp_no_exx", SP, 16'h0100);
    rf.Exx = 1'b1; rf.Ex_Af = 1'b1; tick();
    chk_af("af_alt_kept", 8'h11, 8'hFF);

    // Pair/byte collisions
    rf.Wr_Pair = 1'b1; rf.Wr_Pair_Sel = BC; rf.Wr_Data = 16'h3344;
    rf.Wr_Byte = 1'b1; rf.Wr_Byte_Sel = 3'b001; tick();
    chk_pair("pair_wins", BC, 16'h3344);

    // Async reset overrides a pending exchange
    rf.Ex_Af = 1'b1;
    Reset_n = 1'b0;
    chk_af("async_rst_af", 8'hFF, 8'hFF);
    chk_pair("async_rst_bc", BC, 16'hFFFF);
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    idle();
    rf.Wr_Byte = 1'b1; rf.Wr_Byte_Sel = 3'b111; rf.Wr_Data = 16'h0022; tick();
    chk_af("post_rst_a", 8'h22, 8'hFF);
    rf.Ex_Af = 1'b1; tick();
    chk_af("post_rst_exaf", 8'hFF, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
